pc_predict_unit: RTL and testbench
==================================

# pc_predict_unit

Fetch-stage next-PC generator for the 5-stage pipeline and the parametrised successor of the single-cycle next-PC logic. Holds the architectural fetch PC. Predicts the next PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Resolves branches reported by EX and redirects fetch, with a flush, on any misprediction.

## Interface
Parameters:
- `PC_W`, 16, PC and data width in bits.
- `BTB_ENTRIES`, 8, BTB depth; power of two, 2 to 256.
- `RESET_PC`, 0, PC value loaded at reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  hold fetch PC (hazard unit).
- `ex_valid`  in  1  EX holds a valid instruction.
- `ex_branch`  in  1  EX instruction is a conditional branch.
- `ex_branch_reg`  in  1  target is `ex_rs`, not PC-relative.
- `ex_ccc`  in  3  condition code.
- `ex_flags`  in  3  flags, ordered {Z,V,N}.
- `ex_imm`  in  9  signed word offset.
- `ex_pc`  in  PC_W  PC of the EX instruction.
- `ex_rs`  in  PC_W  register target.
- `ex_pred_taken`  in  1  prediction carried down the pipe for this instruction.
- `ex_pred_target`  in  PC_W  predicted target carried down the pipe for this instruction.
- `pc`  out  PC_W  current fetch PC.
- `pred_taken`  out  1  prediction for `pc`; pipe it to EX.
- `pred_target`  out  PC_W  predicted next PC for `pc`; pipe it to EX.
- `flush`  out  1  squash IF/ID; asserted in the redirect cycle.

## Operation
- Condition evaluation, `cond_ok`:
  - 000: Z=0
  - 001: Z=1
  - 010: Z=0 and N=0
  - 011: N=1
  - 100: Z=1, or (Z=0 and N=0)
  - 101: Z=1 or N=1
  - 110: V=1
  - 111: always true
- `resolve` = `ex_valid & ex_branch`.
- `taken` = `resolve & cond_ok`.
- Actual target: `ex_rs` if `ex_branch_reg`; otherwise `ex_pc + 2 + sext(ex_imm<<1)`. Arithmetic is modulo 2^PC_W; the immediate is sign-extended from bit 9 after the shift.
- `actual_next` = taken ? target : `ex_pc+2`.
- `mispredict` = resolve & (`taken != ex_pred_taken` | (taken & target != `ex_pred_target`)).
- BTB indexing:
  - index = `pc[IDX:1]`, where IDX = log2(BTB_ENTRIES).
  - tag = `pc[PC_W-1:IDX+1]`.
  - Each entry holds valid, tag, target and a 2-bit counter.
- Lookup is combinational from `pc`:
  - `pred_taken` = hit & counter[1].
  - `pred_target` = pred_taken ? entry target : pc+2.
- Next PC, in priority order:
  1. mispredict → `actual_next`.
  2. stall → hold.
  3. otherwise → `pred_target`.
- A redirect overrides a stall.
- `flush` = mispredict (combinational, same cycle as the resolve).
- BTB update, only on resolve, at the EX index/tag:
  - Hit: counter +1 if taken, −1 if not taken, saturating at 00/11. Target overwritten with the actual target if taken.
  - Miss and taken: allocate with valid=1, the tag, the target, counter=10.
  - Miss and not taken: no allocation.
- Non-branch instructions never touch the BTB.

## Timing
- Reset, asynchronous:
  - `pc`=RESET_PC.
  - All BTB valid bits=0 and counters=01.
  - Outputs therefore read `pred_taken`=0, `pred_target`=RESET_PC+2, `flush`=0.
- Latency:
  - Lookup is zero-cycle from `pc`.
  - Redirect appears on `pc` one edge after the resolve cycle.
  - Mispredict penalty is 2 fetch slots.
- Lookup and update to the same entry in the same cycle: the lookup sees old contents; the write lands at the edge.
- Reset deasserted mid-operation: the first edge after deassertion fetches from RESET_PC. No partial BTB state survives.
- A stalled cycle with resolve still updates the BTB.
- A second `ex_valid` of the same instruction must not occur; the pipeline guarantees it.
- PC wrap: `pc+2` at 0xFFFE yields 0x0000.

## Structure
- Package `cpu_pkg` holds:
  - flag index constants (Z=2, V=1, N=0);
  - ccc localparams;
  - function `cond_eval(ccc, flags)`, shared with any future EX-side users.
- Sub-module `btb_dm`, parametrised on PC_W and BTB_ENTRIES:
  - one combinational read port;
  - one write port with counter update logic;
  - asynchronous clear of valid bits and counters.
- Top level holds the PC register, target adders and mispredict compare.

## Test plan
- Reset, then 4 unstalled cycles → `pc` = 0,2,4,6, `pred_taken`=0, `flush`=0.
- Branch at 0x0006, ccc=111, imm=+4, pred_taken=0 → `flush`=1 that cycle; next `pc`=0x0010; BTB entry 3 valid, counter=10.
- Refetch 0x0006 → `pred_taken`=1, `pred_target`=0x0010. Resolve not-taken (ccc=001, Z=0) → flush, `pc`=0x0008, counter=01. Next fetch of 0x0006 predicts not taken.
- `ex_branch_reg` taken to `ex_rs`=0x1234 while `ex_pred_target`=0x2000 → mispredict, `pc`=0x1234, BTB target updated.
- `stall`=1 for 3 cycles → `pc` held. A mispredict asserted during the stall → redirect still taken the next edge.
- All eight ccc values × representative flag sets → `flush`/next PC match `cond_eval`. Negative imm (0x1FF) from 0x0000 wraps to 0x0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: flag positions, branch condition codes and the
// condition evaluator used by the fetch predictor (and later by EX).
package cpu_pkg;

  // Bit positions inside the {Z,V,N} flag vector.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    CCC_NE = 3'b000,  // Z=0
    CCC_EQ = 3'b001,  // Z=1
    CCC_GT = 3'b010,  // Z=0 and N=0
    CCC_LT = 3'b011,  // N=1
    CCC_GE = 3'b100,  // Z=1 or (Z=0 and N=0)
    CCC_LE = 3'b101,  // Z=1 or N=1
    CCC_VS = 3'b110,  // V=1
    CCC_AL = 3'b111   // always
  } ccc_e;

  function automatic logic cond_eval(input logic [2:0] ccc, input logic [2:0] flags);
    logic z, v, n, ok;
    z  = flags[FLAG_Z];
    v  = flags[FLAG_V];
    n  = flags[FLAG_N];
    ok = 1'b1;
    case (ccc)
      CCC_NE:  ok = ~z;
      CCC_EQ:  ok = z;
      CCC_GT:  ok = ~z & ~n;
      CCC_LT:  ok = n;
      CCC_GE:  ok = z | (~z & ~n);
      CCC_LE:  ok = z | n;
      CCC_VS:  ok = v;
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// One combinational read port (fetch) and one write port (EX resolve).
// PC bit 0 is always zero for halfword-aligned code, so ports start at bit 1.
module btb_dm #(
  parameter int PC_W        = 16,
  parameter int BTB_ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  // read port
  input  logic [PC_W-1:1] rd_pc_i,
  output logic            rd_taken_o,
  output logic [PC_W-1:0] rd_target_o,
  // write port
  input  logic            wr_en_i,
  input  logic [PC_W-1:1] wr_pc_i,
  input  logic            wr_taken_i,
  input  logic [PC_W-1:0] wr_target_i
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - 1 - IDX;

  logic [BTB_ENTRIES-1:0]            valid_q;
  logic [BTB_ENTRIES-1:0][1:0]       ctr_q;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [BTB_ENTRIES-1:0][PC_W-1:0]  target_q;

  logic [IDX-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;
  logic [1:0]       ctr_d;

  assign rd_idx = rd_pc_i[IDX:1];
  assign rd_tag = rd_pc_i[PC_W-1:IDX+1];
  assign wr_idx = wr_pc_i[IDX:1];
  assign wr_tag = wr_pc_i[PC_W-1:IDX+1];

  // Read sees the pre-edge contents, so a same-cycle update is invisible here.
  assign rd_hit      = valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag);
  assign rd_taken_o  = rd_hit & ctr_q[rd_idx][1];
  assign rd_target_o = target_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] & (tag_q[wr_idx] == wr_tag);

  // Saturating counter step for a hitting update.
  always_comb begin
    ctr_d = ctr_q[wr_idx];
    if (wr_taken_i) begin
      if (ctr_q[wr_idx] != 2'b11) ctr_d = ctr_q[wr_idx] + 2'b01;
    end else begin
      if (ctr_q[wr_idx] != 2'b00) ctr_d = ctr_q[wr_idx] - 2'b01;
    end
  end

  // Valid bits and counters: cleared asynchronously, allocated on taken miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (wr_en_i) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_d;
      end else if (wr_taken_i) begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target payload: only meaningful under valid, so no reset needed.
  // A taken resolve writes both on hit (tag unchanged) and on allocation.
  always_ff @(posedge clk) begin
    if (wr_en_i && wr_taken_i) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target_i;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage next-PC generator: fetch PC register, BTB-based prediction,
// branch resolution from EX and redirect/flush on misprediction.
module pc_predict_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter int              BTB_ENTRIES = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_branch_reg,
  input  logic [2:0]      ex_ccc,
  input  logic [2:0]      ex_flags,
  input  logic [8:0]      ex_imm,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_rs,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic [PC_W-1:0] pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic            flush
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus2, ex_pc_plus2, imm_sext, br_target, actual_next;
  logic [PC_W-1:0] btb_target;
  logic            btb_taken;
  logic            resolve, taken, mispredict;

  // ---- EX-side resolution ----
  assign resolve     = ex_valid & ex_branch;
  assign taken       = resolve & cond_eval(ex_ccc, ex_flags);
  assign ex_pc_plus2 = ex_pc + PC_W'(2);
  // Word offset: shift to bytes, then sign-extend from bit 9.
  assign imm_sext    = PC_W'($signed({ex_imm, 1'b0}));
  assign br_target   = ex_branch_reg ? ex_rs : (ex_pc_plus2 + imm_sext);
  assign actual_next = taken ? br_target : ex_pc_plus2;
  assign mispredict  = resolve &
                       ((taken != ex_pred_taken) |
                        (taken & (br_target != ex_pred_target)));

  // ---- Fetch-side prediction ----
  assign pc_plus2 = pc_q + PC_W'(2);

  btb_dm #(
    .PC_W       (PC_W),
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_pc_i    (pc_q[PC_W-1:1]),
    .rd_taken_o (btb_taken),
    .rd_target_o(btb_target),
    .wr_en_i    (resolve),
    .wr_pc_i    (ex_pc[PC_W-1:1]),
    .wr_taken_i (taken),
    .wr_target_i(br_target)
  );

  assign pc          = pc_q;
  assign pred_taken  = btb_taken;
  assign pred_target = btb_taken ? btb_target : pc_plus2;
  assign flush       = mispredict;

  // Next fetch PC: redirect beats stall, stall beats prediction.
  always_comb begin
    pc_d = pred_target;
    if (mispredict)  pc_d = actual_next;
    else if (stall)  pc_d = pc_q;
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed and randomized bench for pc_predict_unit against a behavioural
// model of the fetch PC and BTB kept as plain integer arrays.
module tb_pc_predict_unit;

  localparam int ENT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, ex_valid, ex_branch, ex_branch_reg, ex_pred_taken;
  logic [2:0]  ex_ccc, ex_flags;
  logic [8:0]  ex_imm;
  logic [15:0] ex_pc, ex_rs, ex_pred_target;
  logic [15:0] pc, pred_target;
  logic        pred_taken, flush;

  always #5 clk = ~clk;

  pc_predict_unit #(.PC_W(16), .BTB_ENTRIES(ENT), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_branch_reg(ex_branch_reg),
    .ex_ccc(ex_ccc), .ex_flags(ex_flags), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_rs(ex_rs), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state
  bit m_val [ENT];
  int m_tag [ENT];
  int m_tgt [ENT];
  int m_ctr [ENT];
  int m_pc;

  typedef struct { int pc; bit pt; int ptg; } hent_t;
  hent_t hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ref(input int c, input bit z, input bit v, input bit n);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return z || n;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_val[i] = 1'b0;
      m_ctr[i] = 1;
      m_tag[i] = 0;
      m_tgt[i] = 0;
    end
    m_pc = 0;
  endtask

  task automatic lookup(input int p, output bit t, output int tg);
    int idx, tag;
    idx = (p / 2) % ENT;
    tag = p / (2 * ENT);
    t   = m_val[idx] && (m_tag[idx] == tag) && (m_ctr[idx] >= 2);
    tg  = t ? m_tgt[idx] : ((p + 2) & 'hFFFF);
  endtask

  task automatic drive(input bit v, input bit br, input bit breg, input logic [2:0] c,
                       input logic [2:0] f, input logic [8:0] imm, input logic [15:0] xpc,
                       input logic [15:0] rs, input bit pt, input logic [15:0] ptg, input bit st);
    ex_valid = v; ex_branch = br; ex_branch_reg = breg; ex_ccc = c; ex_flags = f;
    ex_imm = imm; ex_pc = xpc; ex_rs = rs; ex_pred_taken = pt; ex_pred_target = ptg;
    stall = st;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  // Check outputs against the model, cross one rising edge, advance the model.
  task automatic cycle();
    bit lt, res, tk, mis, hit;
    int ltg, simm, tgt, act, idx, tag;
    lookup(m_pc, lt, ltg);
    res  = ex_valid && ex_branch;
    simm = ex_imm[8] ? int'(ex_imm) - 512 : int'(ex_imm);
    tgt  = ex_branch_reg ? int'(ex_rs) : ((int'(ex_pc) + 2 + 2 * simm) & 'hFFFF);
    tk   = res && cond_ref(int'(ex_ccc), ex_flags[2], ex_flags[1], ex_flags[0]);
    mis  = res && ((tk != ex_pred_taken) || (tk && tgt != int'(ex_pred_target)));
    act  = tk ? tgt : ((int'(ex_pc) + 2) & 'hFFFF);
    chk("pc",          32'(pc),          32'(m_pc));
    chk("pred_taken",  32'(pred_taken),  32'(lt));
    chk("pred_target", 32'(pred_target), 32'(ltg));
    chk("flush",       32'(flush),       32'(mis));
    @(posedge clk);
    if (mis)         m_pc = act;
    else if (!stall) m_pc = ltg;
    if (res) begin
      idx = (int'(ex_pc) / 2) % ENT;
      tag = int'(ex_pc) / (2 * ENT);
      hit = m_val[idx] && (m_tag[idx] == tag);
      if (hit) begin
        if (tk) begin
          m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          m_tgt[idx] = tgt;
        end else begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end
      end else if (tk) begin
        m_val[idx] = 1'b1;
        m_tag[idx] = tag;
        m_tgt[idx] = tgt;
        m_ctr[idx] = 2;
      end
    end
    @(negedge clk);
  endtask

  // Reg-indirect branch from 0x0040 used to steer fetch to a chosen PC.
  task automatic redirect_to(input logic [15:0] dst);
    drive(1'b1, 1'b1, 1'b1, 3'd7, 3'd0, 9'd0, 16'h0040, dst, 1'b0, 16'h0042, 1'b0);
    cycle();
  endtask

  initial begin
    bit lt;
    int ltg;
    rst_n = 1'b0;
    idle();
    model_reset();
    chk("rst_pc",          32'(pc),          32'h0000);
    chk("rst_pred_taken",  32'(pred_taken),  32'h0);
    chk("rst_pred_target", 32'(pred_target), 32'h0002);
    chk("rst_flush",       32'(flush),       32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("seq_pc", 32'(pc), 32'(2 * i));
      chk("seq_pt", 32'(pred_taken), 32'h0);
      cycle();
    end

    // Always-taken branch at 0x0006, predicted not taken
    drive(1'b1, 1'b1, 1'b0, 3'd7, 3'd0, 9'd4, 16'h0006, 16'h0000, 1'b0, 16'h0008, 1'b0);
    chk("br6_flush", 32'(flush), 32'h1);
    cycle();
    chk("br6_pc", 32'(pc), 32'h0010);

    // Refetch 0x0006: counter 10 predicts taken
    redirect_to(16'h0006);
    idle();
    chk("re6_pt",  32'(pred_taken),  32'h1);
    chk("re6_ptg", 32'(pred_target), 32'h0010);
    cycle();
    // Resolve not taken (EQ with Z=0)
    drive(1'b1, 1'b1, 1'b0, 3'd1, 3'b000, 9'd4, 16'h0006, 16'h0000, 1'b1, 16'h0010, 1'b0);
    chk("nt6_flush", 32'(flush), 32'h1);
    cycle();
    chk("nt6_pc", 32'(pc), 32'h0008);
    redirect_to(16'h0006);
    idle();
    chk("ctr01_pt",  32'(pred_taken),  32'h0);
    chk("ctr01_ptg", 32'(pred_target), 32'h0008);
    cycle();

    // Register target differs from predicted target
    drive(1'b1, 1'b1, 1'b1, 3'd7, 3'd0, 9'd0, 16'h0006, 16'h1234, 1'b1, 16'h2000, 1'b0);
    chk("reg_flush", 32'(flush), 32'h1);
    cycle();
    chk("reg_pc", 32'(pc), 32'h1234);
    redirect_to(16'h0006);
    idle();
    chk("reg_btb_pt",  32'(pred_taken),  32'h1);
    chk("reg_btb_ptg", 32'(pred_target), 32'h1234);
    cycle();

    // Stall holds the PC; redirect overrides stall
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
      cycle();
      chk("stall_pc", 32'(pc), 32'h1234);
    end
    drive(1'b1, 1'b1, 1'b1, 3'd7, 3'd0, 9'd0, 16'h0040, 16'h0200, 1'b0, 16'h0000, 1'b1);
    chk("stall_mis_flush", 32'(flush), 32'h1);
    cycle();
    chk("stall_mis_pc", 32'(pc), 32'h0200);

    // Every condition code against every flag combination
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        drive(1'b1, 1'b1, 1'b0, 3'(c), 3'(f), 9'h010, 16'h0100, 16'h0000, 1'b0, 16'h0102, 1'b0);
        chk("ccc_flush", 32'(flush), 32'(cond_ref(c, f[2], f[1], f[0])));
        cycle();
      end
    end

    // Negative offset from 0x0000 lands back on 0x0000
    drive(1'b1, 1'b1, 1'b0, 3'd7, 3'd0, 9'h1FF, 16'h0000, 16'h0000, 1'b0, 16'h0002, 1'b0);
    cycle();
    chk("negimm_pc", 32'(pc), 32'h0000);

    // PC wrap at 0xFFFE
    redirect_to(16'hFFFE);
    chk("wrap_pc0", 32'(pc), 32'hFFFE);
    idle();
    chk("wrap_ptg", 32'(pred_target), 32'h0000);
    cycle();
    chk("wrap_pc1", 32'(pc), 32'h0000);

    // Asynchronous reset mid-operation clears PC and BTB
    idle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk("arst_pc", 32'(pc), 32'h0000);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    redirect_to(16'h0006);
    idle();
    chk("arst_btb_pt", 32'(pred_taken), 32'h0);
    cycle();

    // Randomized traffic; EX mostly replays what fetch predicted two slots ago
    for (int n = 0; n < 2000; n++) begin
      hent_t h, e;
      lookup(m_pc, lt, ltg);
      h.pc = m_pc; h.pt = lt; h.ptg = ltg;
      hist.push_back(h);
      if (hist.size() > 3) void'(hist.pop_front());
      if (hist.size() >= 3 && $urandom_range(0, 9) < 7) begin
        e = hist[0];
      end else begin
        e.pc  = 2 * $urandom_range(0, 63);
        e.pt  = 1'($urandom_range(0, 1));
        e.ptg = 2 * $urandom_range(0, 127);
      end
      drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, 3'($urandom), 3'($urandom),
            9'($urandom_range(0, 511)), 16'(e.pc), 16'(2 * $urandom_range(0, 127)),
            e.pt, 16'(e.ptg), $urandom_range(0, 3) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
